fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Shares the write port of one synchronous FIFO between NUM_REQ producers using round-robin arbitration with bounded bursts. Each producer uses a valid/ready handshake. The arbiter drives the FIFO write enable and write data, and back-pressures producers from the FIFO full flag. It sits directly in front of the FIFO write side, and the FIFO read side is untouched.

Parameters:
NUM_REQ, 4, number of producers (≥2).
DATA_WIDTH, 8, FIFO word width.
MAX_BURST, 4, maximum consecutive beats per grant (≥1).

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  NUM_REQ  per-producer data valid.
req_data  input  NUM_REQ*DATA_WIDTH  packed producer data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  output  NUM_REQ  per-producer accept.
fifo_full  input  1  FIFO full flag.
fifo_wr_en  output  1  FIFO write enable.
fifo_data_in  output  DATA_WIDTH  FIFO write data.
grant_valid  output  1  a grant is active.
grant_id  output  $clog2(NUM_REQ)  index of the granted producer; 0 when no grant is active.

Behaviour:
- FSM states: IDLE and GRANT. Registers: state, gnt (grant index), rr_ptr (next highest-priority index), beat_cnt (width $clog2(MAX_BURST)+1).
- Reset (async, any time, including mid-burst): state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0.
  - All outputs low/zero immediately, because outputs decode from state.
  - A beat in flight on the reset edge is not written.
- Outputs are combinational from registers plus inputs:
  - grant_valid = (state==GRANT).
  - grant_id = gnt when grant_valid, else 0.
  - xfer = grant_valid & req_valid[gnt] & !fifo_full.
  - fifo_wr_en = xfer.
  - fifo_data_in = req_data slice gnt when grant_valid, else 0.
  - req_ready[i] = grant_valid & (i==gnt) & !fifo_full.
  - Zero-latency path: a beat is written in the same cycle valid & ready are high.
- IDLE:
  - If any req_valid is high: select the first asserted index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ (wrap-around).
  - Load gnt with that index, clear beat_cnt, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, each cycle:
  - If xfer: beat_cnt += 1.
  - Release condition: (xfer & beat_cnt==MAX_BURST-1) OR !req_valid[gnt].
  - On release: state→IDLE, rr_ptr ← (gnt+1) mod NUM_REQ, beat_cnt←0.
  - Otherwise stay in GRANT.
- Re-arbitration bubble: exactly one IDLE cycle between consecutive grants. Peak throughput is MAX_BURST/(MAX_BURST+1) beats per cycle.
- fifo_full:
  - While full, the grant is held, no beat is counted, ready is low, and there is no timeout.
  - Writing resumes the first cycle full deasserts.
- Producer dropping valid mid-burst: release on that cycle with no write. The producer is re-arbitrated later at rr_ptr priority like any other.
- Protocol: producers must hold req_valid and req_data stable until accepted. The arbiter does not check this.
- Fairness: a continuously-requesting producer waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles plus FIFO-full stall cycles.
- Non-granted producers' data is never written. fifo_wr_en is never high while fifo_full is high.

Test Plan:
1. MAX_BURST=4, only producer 1 valid with data 0x10..0x15, FIFO never full -> FIFO receives 0x10–0x13, one IDLE cycle, then 0x14–0x15; grant_id=1 throughout the grants; rr_ptr=2 after each release.
2. All four producers valid continuously, each sending 8 beats -> grant order 0,1,2,3,0,1,2,3; each grant is 4 writes; every grant is separated by one bubble cycle.
3. Producer 2 granted, fifo_full asserted for 5 cycles after beat 2 -> fifo_wr_en and req_ready[2] low for those 5 cycles; grant_id stays 2; beats 3–4 are written after full drops; the burst totals 4 writes.
4. Producer 0 drops valid after 2 beats -> release with no write on the drop cycle; next IDLE grants producer 1 if it is valid; rr_ptr=1.
5. Wrap-around: rr_ptr=3, only producers 0 and 3 valid -> producer 3 granted first, then producer 0.
6. Assert rst mid-burst (beat 2 of producer 1) asynchronously between edges -> fifo_wr_en, req_ready, grant_valid and grant_id go to 0 immediately; after release, the first grant uses rr_ptr=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port between NUM_REQ valid/ready
// producers. Round-robin arbitration with bursts capped at MAX_BURST beats.
// One IDLE re-arbitration cycle sits between consecutive grants.
//
// Ports:
//   clk          - clock, all state on rising edge
//   rst          - asynchronous active-high reset
//   req_valid    - per-producer data valid
//   req_data     - packed producer data, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    - per-producer accept (zero-latency, decoded from grant state)
//   fifo_full    - FIFO full flag, stalls the active grant
//   fifo_wr_en   - FIFO write enable
//   fifo_data_in - FIFO write data (granted producer's slice, else 0)
//   grant_valid  - a grant is active
//   grant_id     - granted producer index, 0 when no grant
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   gnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   beat_cnt;

    logic               pick_found_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic [DATA_WIDTH-1:0] sel_data_c;
    logic               xfer_c;
    logic               rel_c;

    // First asserted requester scanning from rr_ptr upward with wrap-around
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!pick_found_c && req_valid[IDX_W'((32'(rr_ptr) + k) % NUM_REQ)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Data slice of the granted producer
    always_comb begin
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt == IDX_W'(i)) begin
                sel_data_c = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant_valid  = (state == GRANT);
    assign grant_id     = grant_valid ? gnt : '0;
    assign xfer_c       = grant_valid & req_valid[gnt] & ~fifo_full;
    assign fifo_wr_en   = xfer_c;
    assign fifo_data_in = grant_valid ? sel_data_c : '0;

    // Burst ends on its last counted beat, or when the owner withdraws valid
    assign rel_c = (xfer_c && (beat_cnt == LAST_BEAT)) || !req_valid[gnt];

    // Ready only to the owner, and never while the FIFO is full
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && !fifo_full && (gnt == IDX_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Arbitration FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found_c) begin
                        gnt      <= pick_idx_c;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel_c) begin
                        state    <= IDLE;
                        rr_ptr   <= (gnt == LAST_IDX) ? '0 : gnt + IDX_W'(1);
                        beat_cnt <= '0;
                    end else if (xfer_c) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
